// File: rtl/lcd_text_editor.sv
// HD44780-class character-LCD text editor: runs the power-up init sequence, then services
// edge-detected digit, cursor, backspace and clear keys while tracking a wrapping cursor.
module lcd_text_editor #(
  parameter int unsigned COLS      = 16,
  parameter int unsigned ROWS      = 2,
  parameter int unsigned INIT_WAIT = 70,
  parameter int unsigned CMD_WAIT  = 30,
  parameter int unsigned CLR_WAIT  = 100,
  parameter int unsigned CNT_W     = 8,
  localparam int unsigned ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned COL_W    = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       num,
  input  logic [1:0]       ctrl,
  input  logic             bksp,
  input  logic             clr,
  output logic             E,
  output logic             RS,
  output logic             RW,
  output logic [7:0]       DATA,
  output logic             busy,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col
);

  // Bus words are {RS, RW, DATA}
  localparam logic [9:0] WordNop   = 10'h00F;
  localparam logic [9:0] WordFunc  = 10'h038;
  localparam logic [9:0] WordEntry = 10'h006;
  localparam logic [9:0] WordClear = 10'h001;
  localparam logic [9:0] WordSpace = 10'h220;

  localparam logic [CNT_W-1:0] CntData    = CNT_W'(8);
  localparam logic [CNT_W-1:0] CntBkSpace = CNT_W'(11);
  localparam logic [CNT_W-1:0] CntAddr    = CNT_W'(13);
  localparam logic [CNT_W-1:0] CntBkAddr  = CNT_W'(14);

  typedef enum logic [3:0] {
    StPwrWait,
    StFuncSet,
    StDispOn,
    StEntry,
    StClear,
    StIdle,
    StWrite,
    StMove,
    StBksp
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, limit;
  logic             done;
  logic [ROW_W-1:0] row_q, row_d, adv_row, ret_row;
  logic [COL_W-1:0] col_q, col_d, adv_col, ret_col;
  logic [1:0]       dir_q, dir_d;
  logic [9:0]       word;

  logic [9:0] num_q, num_prev_q, num_pls;
  logic [1:0] ctrl_q, ctrl_prev_q, ctrl_pls;
  logic       bksp_q, bksp_prev_q, bksp_pls;
  logic       clr_q, clr_prev_q, clr_pls;

  // Inputs are registered once, then compared against their previous value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_q       <= '0;
      num_prev_q  <= '0;
      ctrl_q      <= '0;
      ctrl_prev_q <= '0;
      bksp_q      <= 1'b0;
      bksp_prev_q <= 1'b0;
      clr_q       <= 1'b0;
      clr_prev_q  <= 1'b0;
    end else begin
      num_q       <= num;
      num_prev_q  <= num_q;
      ctrl_q      <= ctrl;
      ctrl_prev_q <= ctrl_q;
      bksp_q      <= bksp;
      bksp_prev_q <= bksp_q;
      clr_q       <= clr;
      clr_prev_q  <= clr_q;
    end
  end

  assign num_pls  = num_q & ~num_prev_q;
  assign ctrl_pls = ctrl_q & ~ctrl_prev_q;
  assign bksp_pls = bksp_q & ~bksp_prev_q;
  assign clr_pls  = clr_q & ~clr_prev_q;

  function automatic logic [9:0] ddram_word(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    int unsigned base;
    base = 0;
    if (32'(r) == 1) begin
      base = 'h40;
    end else if (32'(r) == 2) begin
      base = COLS;
    end else if (32'(r) == 3) begin
      base = 'h40 + COLS;
    end
    return {3'b001, 7'(base + 32'(c))};
  endfunction

  // Keys map bit9..bit1 to '1'..'9' and bit0 to '0'; anything but one key gives a space.
  function automatic logic [7:0] key_char(input logic [9:0] k);
    logic [7:0] ch;
    ch = 8'h20;
    if ($onehot(k)) begin
      for (int i = 0; i < 10; i++) begin
        if (k[i]) ch = (i == 0) ? 8'h30 : 8'(58 - i);
      end
    end
    return ch;
  endfunction

  always_comb begin
    adv_row = row_q;
    adv_col = col_q + 1'b1;
    if (col_q == COL_W'(COLS - 1)) begin
      adv_col = '0;
      adv_row = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
    end
    ret_row = row_q;
    ret_col = col_q - 1'b1;
    if (col_q == '0) begin
      ret_col = COL_W'(COLS - 1);
      ret_row = (row_q == '0) ? ROW_W'(ROWS - 1) : row_q - 1'b1;
    end
  end

  always_comb begin
    case (state_q)
      StPwrWait: limit = CNT_W'(INIT_WAIT);
      StClear:   limit = CNT_W'(CLR_WAIT);
      default:   limit = CNT_W'(CMD_WAIT);
    endcase
  end

  assign done = (cnt_q == limit);

  always_comb begin
    state_d = state_q;
    cnt_d   = done ? '0 : cnt_q + 1'b1;
    row_d   = row_q;
    col_d   = col_q;
    dir_d   = dir_q;
    word    = WordNop;
    unique case (state_q)
      StPwrWait: begin
        word = WordClear;
        if (done) state_d = StFuncSet;
      end
      StFuncSet: begin
        word = WordFunc;
        if (done) state_d = StDispOn;
      end
      StDispOn: begin
        word = WordNop;
        if (done) state_d = StEntry;
      end
      StEntry: begin
        word = WordEntry;
        if (done) state_d = StClear;
      end
      StClear: begin
        word = WordClear;
        if (done) begin
          state_d = StIdle;
          row_d   = '0;
          col_d   = '0;
        end
      end
      StIdle: begin
        cnt_d = '0;
        if (clr_pls) begin
          state_d = StClear;
        end else if (bksp_pls) begin
          state_d = StBksp;
        end else if (|num_pls) begin
          state_d = StWrite;
        end else if (|ctrl_pls) begin
          state_d = StMove;
        end
      end
      StWrite: begin
        if (cnt_q == CntData) word = {2'b10, key_char(num_q)};
        if (cnt_q == CntAddr) word = ddram_word(adv_row, adv_col);
        if (done) begin
          state_d = StIdle;
          row_d   = adv_row;
          col_d   = adv_col;
        end
      end
      StMove: begin
        // Direction is latched at the address slot and applied on exit.
        if (cnt_q == CntData) begin
          dir_d = ctrl_q;
          if (ctrl_q == 2'b10) begin
            word = ddram_word(ret_row, ret_col);
          end else if (ctrl_q == 2'b01) begin
            word = ddram_word(adv_row, adv_col);
          end
        end
        if (done) begin
          state_d = StIdle;
          if (dir_q == 2'b10) begin
            row_d = ret_row;
            col_d = ret_col;
          end else if (dir_q == 2'b01) begin
            row_d = adv_row;
            col_d = adv_col;
          end
        end
      end
      StBksp: begin
        if (cnt_q == CntData || cnt_q == CntBkAddr) word = ddram_word(ret_row, ret_col);
        if (cnt_q == CntBkSpace) word = WordSpace;
        if (done) begin
          state_d = StIdle;
          row_d   = ret_row;
          col_d   = ret_col;
        end
      end
      default: state_d = StPwrWait;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StPwrWait;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      dir_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dir_q   <= dir_d;
    end
  end

  assign {RS, RW, DATA} = word;
  assign E       = clk;
  assign busy    = (state_q != StIdle);
  assign cur_row = row_q;
  assign cur_col = col_q;

endmodule

// File: tb/tb_lcd_text_editor.sv
// Randomized scoreboard bench for lcd_text_editor: a cursor-position model predicts every
// bus word of each operation; a monitor compares them as the DUT runs.
module tb_lcd_text_editor;

  localparam int COLS1     = 16;
  localparam int ROWS1     = 2;
  localparam int NPOS      = COLS1 * ROWS1;
  localparam int INIT_WAIT = 70;
  localparam int CMD_WAIT  = 30;
  localparam int CLR_WAIT  = 100;
  localparam logic [9:0] NOP = 10'h00F;

  logic       clk, rst;
  logic [9:0] num;
  logic [1:0] ctrl;
  logic       bksp, clr;
  logic       E, RS, RW, busy;
  logic [7:0] DATA;
  logic [0:0] cur_row;
  logic [3:0] cur_col;
  logic [9:0] word1;

  logic [9:0] num2;
  logic [1:0] ctrl2;
  logic       bksp2, clr2;
  logic       E2, RS2, RW2, busy2;
  logic [7:0] DATA2;
  logic [1:0] cur_row2;
  logic [4:0] cur_col2;
  logic [9:0] word2;

  lcd_text_editor dut (
    .clk(clk), .rst(rst), .num(num), .ctrl(ctrl), .bksp(bksp), .clr(clr),
    .E(E), .RS(RS), .RW(RW), .DATA(DATA), .busy(busy), .cur_row(cur_row), .cur_col(cur_col)
  );

  lcd_text_editor #(.COLS(20), .ROWS(4)) dut4 (
    .clk(clk), .rst(rst), .num(num2), .ctrl(ctrl2), .bksp(bksp2), .clr(clr2),
    .E(E2), .RS(RS2), .RW(RW2), .DATA(DATA2), .busy(busy2), .cur_row(cur_row2),
    .cur_col(cur_col2)
  );

  assign word1 = {RS, RW, DATA};
  assign word2 = {RS2, RW2, DATA2};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int len;
    int row;
    int col;
  } txn_t;

  logic [9:0] exp_words[$];
  txn_t       exp_txn[$];
  int         checks = 0;
  int         failures = 0;
  int         pos = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Row r starts at 0x40*(r odd) + COLS*(r >= 2); positions are linear row-major.
  function automatic logic [9:0] m_dd(input int p);
    int r, c, base;
    r = p / COLS1;
    c = p % COLS1;
    base = ((r % 2 == 1) ? 'h40 : 0) + ((r >= 2) ? COLS1 : 0);
    return 10'h080 | 10'(base + c);
  endfunction

  function automatic logic [7:0] m_char(input logic [9:0] n);
    if ($countones(n) != 1) return 8'h20;
    for (int i = 0; i < 10; i++) begin
      if (n[i]) return (i == 0) ? 8'h30 : 8'(8'h30 + 10 - i);
    end
    return 8'h20;
  endfunction

  task automatic push_txn(input int len, input int p);
    txn_t t;
    t.len = len;
    t.row = p / COLS1;
    t.col = p % COLS1;
    exp_txn.push_back(t);
  endtask

  task automatic push_init();
    for (int i = 0; i <= INIT_WAIT; i++) exp_words.push_back(10'h001);
    for (int i = 0; i <= CMD_WAIT; i++) exp_words.push_back(10'h038);
    for (int i = 0; i <= CMD_WAIT; i++) exp_words.push_back(10'h00F);
    for (int i = 0; i <= CMD_WAIT; i++) exp_words.push_back(10'h006);
    for (int i = 0; i <= CLR_WAIT; i++) exp_words.push_back(10'h001);
    push_txn(INIT_WAIT + 1 + 3 * (CMD_WAIT + 1) + CLR_WAIT + 1, 0);
  endtask

  // Reference: the highest-priority pressed key decides the whole operation.
  task automatic expect_op(input logic [9:0] n, input logic [1:0] c, input logic b,
                           input logic cl);
    logic [9:0] wv[0:127];
    int len, np;
    len = 0;
    np  = pos;
    for (int i = 0; i < 128; i++) wv[i] = NOP;
    if (cl) begin
      len = CLR_WAIT + 1;
      for (int i = 0; i < len; i++) wv[i] = 10'h001;
      np = 0;
    end else if (b) begin
      len = CMD_WAIT + 1;
      np  = (pos + NPOS - 1) % NPOS;
      wv[8]  = m_dd(np);
      wv[11] = 10'h220;
      wv[14] = m_dd(np);
    end else if (n != 0) begin
      len = CMD_WAIT + 1;
      np  = (pos + 1) % NPOS;
      wv[8]  = 10'h200 | 10'(m_char(n));
      wv[13] = m_dd(np);
    end else if (c != 0) begin
      len = CMD_WAIT + 1;
      if (c == 2'b10) np = (pos + NPOS - 1) % NPOS;
      if (c == 2'b01) np = (pos + 1) % NPOS;
      if (c != 2'b11) wv[8] = m_dd(np);
    end
    for (int i = 0; i < len; i++) exp_words.push_back(wv[i]);
    if (len > 0) push_txn(len, np);
    pos = np;
  endtask

  task automatic drive_keys(input logic [9:0] n, input logic [1:0] c, input logic b,
                            input logic cl, input int hold);
    @(posedge clk);
    #1;
    num = n; ctrl = c; bksp = b; clr = cl;
    repeat (hold) @(posedge clk);
    #1;
    num = '0; ctrl = '0; bksp = 1'b0; clr = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", k);
    end
    @(negedge clk);
  endtask

  task automatic press(input logic [9:0] n, input logic [1:0] c, input logic b, input logic cl);
    expect_op(n, c, b, cl);
    drive_keys(n, c, b, cl, 14);
    wait_idle();
  endtask

  // Monitor: each busy cycle consumes one expected word; each busy fall closes a transaction.
  initial begin
    int len, nbad, bad_off;
    logic [9:0] bad_act, bad_exp, e;
    bit in_txn;
    txn_t t;
    len = 0; nbad = 0; bad_off = 0; in_txn = 0;
    bad_act = '0; bad_exp = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_txn = 0; len = 0; nbad = 0;
      end else if (busy) begin
        in_txn = 1;
        e = 10'h3FF;
        if (exp_words.size() != 0) e = exp_words.pop_front();
        if (word1 !== e) begin
          if (nbad == 0) begin
            bad_off = len; bad_act = word1; bad_exp = e;
          end
          nbad++;
        end
        len++;
      end else begin
        checks++;
        if (word1 !== NOP) begin
          failures++;
          $display("FAIL idle_word: got 0x%0h, expected 0x%0h", word1, NOP);
        end
        if (in_txn) begin
          in_txn = 0;
          checks++;
          if (exp_txn.size() == 0) begin
            failures++;
            $display("FAIL unexpected_op: got op of %0d cycles, expected none", len);
          end else begin
            t = exp_txn.pop_front();
            if (nbad != 0) begin
              failures++;
              $display("FAIL op_words: %0d bad, first at cnt %0d got 0x%0h expected 0x%0h",
                       nbad, bad_off, bad_act, bad_exp);
            end
            checks++;
            if (len != t.len) begin
              failures++;
              $display("FAIL op_len: got %0d cycles, expected %0d", len, t.len);
            end
            checks++;
            if (int'(cur_row) != t.row || int'(cur_col) != t.col) begin
              failures++;
              $display("FAIL op_cursor: got (%0d,%0d), expected (%0d,%0d)",
                       cur_row, cur_col, t.row, t.col);
            end
          end
          len = 0; nbad = 0;
        end
      end
    end
  end

  task automatic op2(input logic [1:0] c, input logic b, output logic [9:0] w8,
                     output logic [9:0] w11, output logic [9:0] w14, output int len);
    bit started;
    started = 0;
    len = 0;
    w8 = 10'h3FF; w11 = 10'h3FF; w14 = 10'h3FF;
    @(posedge clk);
    #1;
    ctrl2 = c; bksp2 = b;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k == 14) begin
        ctrl2 = '0; bksp2 = 1'b0;
      end
      if (busy2) begin
        started = 1;
        if (len == 8) w8 = word2;
        if (len == 11) w11 = word2;
        if (len == 14) w14 = word2;
        len++;
      end else if (started && k > 14) begin
        break;
      end
    end
  endtask

  initial begin
    logic [9:0] n, w8, w11, w14;
    int len, k;
    rst = 1'b0;
    num = '0; ctrl = '0; bksp = 1'b0; clr = 1'b0;
    num2 = '0; ctrl2 = '0; bksp2 = 1'b0; clr2 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_word", 32'(word1), 32'h001);
    check("reset_busy", 32'(busy), 1);
    check("reset_row", 32'(cur_row), 0);
    check("reset_col", 32'(cur_col), 0);
    check("e_follows_clk", 32'(E), 1);

    push_init();
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_idle();

    press('0, 2'b10, 1'b0, 1'b0);
    press('0, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) press('0, 2'b01, 1'b0, 1'b0);
    press(10'b00_0000_0100, 2'b00, 1'b0, 1'b0);
    press('0, 2'b00, 1'b1, 1'b0);
    press('0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) press(10'd1 << $urandom_range(0, 9), 2'b00, 1'b0, 1'b0);
    press('0, 2'b00, 1'b1, 1'b0);

    press(10'b00_0000_0100, 2'b00, 1'b0, 1'b1);
    expect_op('0, 2'b00, 1'b0, 1'b1);
    drive_keys('0, 2'b00, 1'b0, 1'b1, 3);
    drive_keys(10'h020, 2'b00, 1'b0, 1'b0, 5);
    wait_idle();
    press(10'b00_0000_0011, 2'b00, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      n = ($urandom_range(0, 2) == 0) ? 10'd0 :
          (($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'd1 << $urandom_range(0, 9));
      press(n, 2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0));
    end

    // Reset in the middle of a write, at cnt=10.
    @(posedge clk);
    #1;
    num = 10'h001;
    k = 0;
    while (!busy && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("write_started", 32'(busy), 1);
    repeat (10) @(negedge clk);
    #1;
    rst = 1'b0;
    exp_words.delete();
    exp_txn.delete();
    #1;
    check("abort_word", 32'(word1), 32'h001);
    check("abort_busy", 32'(busy), 1);
    check("abort_row", 32'(cur_row), 0);
    check("abort_col", 32'(cur_col), 0);
    num = '0;
    pos = 0;
    repeat (3) @(posedge clk);
    push_init();
    #1;
    rst = 1'b1;
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      n = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'd1 << $urandom_range(0, 9);
      press(n, 2'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), 1'b0);
    end
    repeat (2) @(negedge clk);
    check("queue_drain", 32'(exp_words.size() + exp_txn.size()), 0);

    // 20x4 panel: wrap through row 3 and row 2 base addresses.
    op2(2'b00, 1'b1, w8, w11, w14, len);
    check("p4_bksp_w8", 32'(w8), 32'h0E7);
    check("p4_bksp_w11", 32'(w11), 32'h220);
    check("p4_bksp_w14", 32'(w14), 32'h0E7);
    check("p4_bksp_len", 32'(len), 31);
    check("p4_bksp_row", 32'(cur_row2), 3);
    check("p4_bksp_col", 32'(cur_col2), 19);
    op2(2'b01, 1'b0, w8, w11, w14, len);
    check("p4_right_w8", 32'(w8), 32'h080);
    check("p4_right_pos", {cur_row2, cur_col2}, {2'd0, 5'd0});
    op2(2'b10, 1'b0, w8, w11, w14, len);
    check("p4_left_w8", 32'(w8), 32'h0E7);
    for (int i = 0; i < 20; i++) op2(2'b10, 1'b0, w8, w11, w14, len);
    check("p4_row2_w8", 32'(w8), 32'h0A7);
    check("p4_row2_pos", {cur_row2, cur_col2}, {2'd2, 5'd19});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
